hls_fp32_add_chn_a_skid: RTL

Input-channel stage for the fp32 adder core. It sits between the upstream valid/ready producer of operand A and the core's staller. It buffers up to two operand words in a registered skid FIFO, presents the head word to the core, and drives `chn_a_rsci_wen_comp` to the staller, which ANDs it with the B and O channel completions to form `core_wen`. It pops on a core advance and keeps a saturating stall counter for performance debug.

---
 rtl/hls_fp32_add_chn_a_skid.sv | 114 +++++++++++
 1 files changed

// File: rtl/hls_fp32_add_chn_a_skid.sv
// ---------------------------------------------------------------------------
// hls_fp32_add_chn_a_skid
//
// Operand-A input channel for the fp32 adder core. Sits between the upstream
// valid/ready producer and the core staller. Holds up to two words in a
// registered two-entry skid FIFO, presents the head word to the core, and
// reports A-side completion so the staller can form core_wen.
//
// Ports:
//   nvdla_core_clk       clock, rising-edge
//   nvdla_core_rstn      synchronous active-low reset
//   chn_a_vld            upstream word valid
//   chn_a_rdy            registered ready to upstream
//   chn_a_pd             upstream payload (WIDTH)
//   chn_a_rsci_oswt      core requests an A read this state
//   core_wen             core advance enable from the staller
//   core_wten            registered stall indicator from the staller
//   chn_a_rsci_wen_comp  A side complete: ~oswt | (count != 0)
//   chn_a_rsci_d_mxwt    head-entry payload to the core (WIDTH)
//   chn_a_occ            current occupancy, 0..2
//   chn_a_stall_cnt      saturating count of A-starved stall cycles (CNT_W)
// ---------------------------------------------------------------------------
module hls_fp32_add_chn_a_skid #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             chn_a_vld,
    output logic             chn_a_rdy,
    input  logic [WIDTH-1:0] chn_a_pd,
    input  logic             chn_a_rsci_oswt,
    input  logic             core_wen,
    input  logic             core_wten,
    output logic             chn_a_rsci_wen_comp,
    output logic [WIDTH-1:0] chn_a_rsci_d_mxwt,
    output logic [1:0]       chn_a_occ,
    output logic [CNT_W-1:0] chn_a_stall_cnt
);

    // Storage and pointers
    logic [WIDTH-1:0] entry_q [2];
    logic             wp_q;
    logic             rp_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             rdy_q;
    logic             rdy_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic push;
    logic pop;
    logic stall_inc;
    logic stall_sat;

    assign push = chn_a_vld & rdy_q;
    // core_wen already implies a non-empty FIFO when oswt is set; the count
    // term only guards against a misbehaving staller underflowing the count.
    assign pop  = core_wen & chn_a_rsci_oswt & (count_q != 2'd0);

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Ready is registered so upstream never sees a path from core_wen;
    // the price is that a pop from full re-opens ready one cycle later.
    assign rdy_d = (count_d != 2'd2);

    assign stall_inc = chn_a_rsci_oswt & (count_q == 2'd0) & core_wten;
    assign stall_sat = (stall_cnt_q == {CNT_W{1'b1}});

    // Control state with synchronous reset
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            count_q     <= 2'd0;
            wp_q        <= 1'b0;
            rp_q        <= 1'b0;
            rdy_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            count_q <= count_d;
            rdy_q   <= rdy_d;
            if (push) begin
                wp_q <= ~wp_q;
            end
            if (pop) begin
                rp_q <= ~rp_q;
            end
            if (stall_inc && !stall_sat) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // Payload storage is not reset; a reset cycle blocks the write so a word
    // presented during reset is never captured.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rstn && push) begin
            entry_q[wp_q] <= chn_a_pd;
        end
    end

    assign chn_a_rdy           = rdy_q;
    assign chn_a_occ           = count_q;
    assign chn_a_stall_cnt     = stall_cnt_q;
    assign chn_a_rsci_wen_comp = ~chn_a_rsci_oswt | (count_q != 2'd0);
    assign chn_a_rsci_d_mxwt   = entry_q[rp_q];

endmodule
